// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared state encoding, defaults and the baud divisor helper for the UART frame controller.
package uart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_baud_gen.sv
// Free-running 0..DIV-1 counter; rx_clk_en is high for the single cycle the count sits at DIV-1.
module uart_rx_frame_ctrl_baud_gen #(
  parameter int DIV = 10
) (
  input  logic sys_clk,
  input  logic rst_n,
  output logic rx_clk_en
);

  localparam int            CW   = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (!rst_n)             r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign rx_clk_en = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Drains bytes from the UART receiver, parses [SYNC][LEN][PAYLOAD][CHK] frames and releases a checked
// payload as a valid/ready stream one cycle after the CHK byte; bytes arriving while draining are dropped.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         SYS_CLK_HZ    = 50_000_000,
  parameter int         BAUD          = 115200,
  parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 320
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  output logic       rx_clk_en,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ready_clear,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       frame_ok,
  output logic       err_checksum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_drop
);

  localparam int            DIV       = baud_div(SYS_CLK_HZ, BAUD);
  localparam int            PW        = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);
  localparam int            TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

  state_t        r_state, w_state_nxt;
  logic          r_clr;
  logic [7:0]    r_sum, r_len, r_wr_ptr, r_rd_ptr;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_buf [MAX_LEN];
  logic          r_ok, r_err_cs, r_err_len, r_err_to, r_err_drop;
  logic          w_ok_nxt, w_err_cs_nxt, w_err_len_nxt, w_err_to_nxt, w_err_drop_nxt;
  logic          w_evt, w_to, w_xfer, w_timed;
  logic [7:0]    w_sum_chk;

  uart_rx_frame_ctrl_baud_gen #(.DIV(DIV)) u_baud (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .rx_clk_en (rx_clk_en)
  );

  // A byte event is a fresh rx_ready not yet acknowledged by our clear request.
  assign w_evt     = rx_ready && !r_clr;
  assign w_timed   = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
  assign w_to      = rx_clk_en && (r_tick == TO_LAST);
  assign w_sum_chk = r_sum + rx_data;
  assign pkt_valid = (r_state == ST_DRAIN);
  assign pkt_data  = pkt_valid ? r_buf[r_rd_ptr[PW-1:0]] : 8'h00;
  assign pkt_last  = pkt_valid && (r_rd_ptr == r_len - 8'd1);
  assign w_xfer    = pkt_valid && pkt_ready;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) r_state <= ST_HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ok_nxt       = 1'b0;
    w_err_cs_nxt   = 1'b0;
    w_err_len_nxt  = 1'b0;
    w_err_to_nxt   = 1'b0;
    w_err_drop_nxt = 1'b0;
    unique case (r_state)
      ST_HUNT:
        if (w_evt && rx_data == SYNC_BYTE) w_state_nxt = ST_LEN;
      ST_LEN:
        if (w_evt) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            w_err_len_nxt = 1'b1;
            w_state_nxt   = ST_HUNT;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (w_to) begin
          w_err_to_nxt = 1'b1;
          w_state_nxt  = ST_HUNT;
        end
      ST_PAYLOAD:
        if (w_evt) begin
          if (r_wr_ptr + 8'd1 == r_len) w_state_nxt = ST_CHECK;
        end else if (w_to) begin
          w_err_to_nxt = 1'b1;
          w_state_nxt  = ST_HUNT;
        end
      ST_CHECK:
        if (w_evt) begin
          if (w_sum_chk == 8'd0) begin
            w_ok_nxt    = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_err_cs_nxt = 1'b1;
            w_state_nxt  = ST_HUNT;
          end
        end else if (w_to) begin
          w_err_to_nxt = 1'b1;
          w_state_nxt  = ST_HUNT;
        end
      ST_DRAIN: begin
        w_err_drop_nxt = w_evt;
        if (w_xfer && pkt_last) w_state_nxt = ST_HUNT;
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_clr      <= 1'b0;
      r_sum      <= 8'd0;
      r_len      <= 8'd0;
      r_wr_ptr   <= 8'd0;
      r_rd_ptr   <= 8'd0;
      r_tick     <= '0;
      r_ok       <= 1'b0;
      r_err_cs   <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_to   <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      // The receiver only drops rx_ready on its rx_clk_en, so the clear is held until it does.
      if (w_evt)          r_clr <= 1'b1;
      else if (!rx_ready) r_clr <= 1'b0;
      if (!w_timed || w_evt) r_tick <= '0;
      else if (rx_clk_en)    r_tick <= r_tick + 1'b1;
      r_ok       <= w_ok_nxt;
      r_err_cs   <= w_err_cs_nxt;
      r_err_len  <= w_err_len_nxt;
      r_err_to   <= w_err_to_nxt;
      r_err_drop <= w_err_drop_nxt;
      unique case (r_state)
        ST_HUNT: r_sum <= 8'd0;
        ST_LEN:
          if (w_evt) begin
            r_len    <= rx_data;
            r_sum    <= rx_data;
            r_wr_ptr <= 8'd0;
          end
        ST_PAYLOAD:
          if (w_evt) begin
            r_sum    <= w_sum_chk;
            r_wr_ptr <= r_wr_ptr + 8'd1;
          end
        ST_CHECK: if (w_evt) r_rd_ptr <= 8'd0;
        ST_DRAIN: if (w_xfer) r_rd_ptr <= r_rd_ptr + 8'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (r_state == ST_PAYLOAD && w_evt) r_buf[r_wr_ptr[PW-1:0]] <= rx_data;
  end

  assign rx_ready_clear = r_clr;
  assign frame_ok       = r_ok;
  assign err_checksum   = r_err_cs;
  assign err_len        = r_err_len;
  assign err_timeout    = r_err_to;
  assign err_drop       = r_err_drop;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench: a behavioural receiver handshake feeds byte sequences; pulse counters and a transfer log are checked.
module tb_uart_rx_frame_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       pkt_ready = 1'b1;
  logic       rx_clk_en, rx_ready_clear, pkt_valid, pkt_last;
  logic       frame_ok, err_checksum, err_len, err_timeout, err_drop;
  logic [7:0] pkt_data;

  int n_assert = 0;
  int n_fail = 0;
  int c_ok = 0, c_cs = 0, c_len = 0, c_to = 0, c_drop = 0, c_multi = 0, c_unstable = 0;
  logic [7:0] rec_dat[$];
  logic       rec_last[$];
  logic [7:0] seq[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  int b_ok, b_cs, b_len, b_to, b_drop, b_rec;

  uart_rx_frame_ctrl #(
    .SYS_CLK_HZ(1_600_000), .BAUD(10_000), .SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_TICKS(320)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_clk_en(rx_clk_en), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ready_clear(rx_ready_clear), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_last(pkt_last), .frame_ok(frame_ok), .err_checksum(err_checksum), .err_len(err_len),
    .err_timeout(err_timeout), .err_drop(err_drop)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    c_ok   <= c_ok + int'(frame_ok);
    c_cs   <= c_cs + int'(err_checksum);
    c_len  <= c_len + int'(err_len);
    c_to   <= c_to + int'(err_timeout);
    c_drop <= c_drop + int'(err_drop);
    if (int'(frame_ok) + int'(err_checksum) + int'(err_len) + int'(err_timeout) + int'(err_drop) > 1)
      c_multi <= c_multi + 1;
    if (prev_hold && pkt_valid && pkt_dat_changed(prev_dat)) c_unstable <= c_unstable + 1;
    prev_hold <= pkt_valid && !pkt_ready;
    prev_dat  <= pkt_data;
    if (pkt_valid && pkt_ready) begin
      rec_dat.push_back(pkt_data);
      rec_last.push_back(pkt_last);
    end
  end

  function automatic logic pkt_dat_changed(input logic [7:0] p);
    return pkt_data !== p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Mimics uart_receiver: rx_ready stays up until the clear is seen on an rx_clk_en edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    logic done;
    tick(1);
    rx_data  = b;
    rx_ready = 1'b1;
    done = 1'b0;
    for (n = 0; n < 100 && !done; n++) begin
      tick(1);
      if (rx_ready_clear && rx_clk_en) begin
        tick(1);
        rx_ready = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) chk("clear_wait", 32'(done), 32'd1);
    done = 1'b0;
    for (n = 0; n < 100 && !done; n++) begin
      tick(1);
      if (!rx_ready_clear) done = 1'b1;
    end
    if (!done) chk("clear_drop_wait", 32'(done), 32'd1);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic snap();
    b_ok = c_ok; b_cs = c_cs; b_len = c_len; b_to = c_to; b_drop = c_drop; b_rec = rec_dat.size();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, 32'({rx_clk_en, rx_ready_clear, pkt_data, pkt_valid, pkt_last, frame_ok,
                  err_checksum, err_len, err_timeout, err_drop}), 32'd0);
  endtask

  initial begin
    int n, p0, p1;
    tick(3);
    chk_outs_zero("reset_outputs");
    rst_n = 1'b1;

    // baud enable period
    n = 0;
    while (!rx_clk_en && n < 50) begin tick(1); n++; end
    p0 = n;
    tick(1); n++;
    while (!rx_clk_en && n < 50) begin tick(1); n++; end
    p1 = n;
    chk("baud_period", 32'(p1 - p0), 32'd10);

    // good frame
    snap();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_seq();
    tick(10);
    chk("good_frame_ok", 32'(c_ok - b_ok), 32'd1);
    chk("good_no_err", 32'((c_cs - b_cs) + (c_len - b_len) + (c_to - b_to) + (c_drop - b_drop)), 32'd0);
    chk("good_count", 32'(rec_dat.size() - b_rec), 32'd3);
    if (rec_dat.size() - b_rec == 3) begin
      chk("good_stream", 32'({rec_dat[b_rec], rec_dat[b_rec+1], rec_dat[b_rec+2]}), 32'h112233);
      chk("good_last", 32'({rec_last[b_rec], rec_last[b_rec+1], rec_last[b_rec+2]}), 32'b001);
    end

    // bad checksum, then a good frame
    snap();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_seq();
    tick(10);
    chk("bad_cs_err", 32'(c_cs - b_cs), 32'd1);
    chk("bad_cs_no_pkt", 32'((rec_dat.size() - b_rec) + (c_ok - b_ok)), 32'd0);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_seq();
    tick(10);
    chk("after_cs_ok", 32'(c_ok - b_ok), 32'd1);
    chk("after_cs_count", 32'(rec_dat.size() - b_rec), 32'd3);

    // illegal lengths: zero and MAX_LEN+1
    snap();
    seq = '{8'hA5, 8'h00};
    send_seq();
    tick(3);
    chk("len_zero", 32'(c_len - b_len), 32'd1);
    seq = '{8'hA5, 8'h11};
    send_seq();
    tick(3);
    chk("len_over", 32'(c_len - b_len), 32'd2);
    chk("len_no_other", 32'((c_ok - b_ok) + (c_cs - b_cs) + (c_to - b_to)), 32'd0);

    // held output with drop during backpressure
    snap();
    pkt_ready = 1'b0;
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h81};
    send_seq();
    tick(2);
    chk("hold_valid_last_data", 32'({pkt_valid, pkt_last, pkt_data}), 32'h37E);
    send_byte(8'h55);
    tick(30);
    chk("hold_still", 32'({pkt_valid, pkt_last, pkt_data}), 32'h37E);
    chk("hold_drop", 32'(c_drop - b_drop), 32'd1);
    chk("hold_no_xfer", 32'(rec_dat.size() - b_rec), 32'd0);
    chk("hold_stable", 32'(c_unstable), 32'd0);
    pkt_ready = 1'b1;
    tick(1);
    chk("hold_released", 32'(pkt_valid), 32'd0);
    chk("hold_xfer_count", 32'(rec_dat.size() - b_rec), 32'd1);
    if (rec_dat.size() - b_rec == 1)
      chk("hold_xfer", 32'({rec_last[b_rec], rec_dat[b_rec]}), 32'h17E);

    // inter-byte timeout
    snap();
    seq = '{8'hA5, 8'h02, 8'h11};
    send_seq();
    tick(3100);
    chk("timeout_early", 32'(c_to - b_to), 32'd0);
    tick(200);
    chk("timeout_fired", 32'(c_to - b_to), 32'd1);
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h81};
    send_seq();
    tick(5);
    chk("post_to_ok", 32'(c_ok - b_ok), 32'd1);
    chk("post_to_count", 32'(rec_dat.size() - b_rec), 32'd1);
    if (rec_dat.size() - b_rec == 1) chk("post_to_data", 32'(rec_dat[b_rec]), 32'h7E);

    // reset in the middle of a payload
    snap();
    seq = '{8'hA5, 8'h03, 8'h11};
    send_seq();
    rst_n = 1'b0;
    tick(1);
    chk_outs_zero("midframe_reset");
    rst_n = 1'b1;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_seq();
    tick(10);
    chk("reset_recover_ok", 32'(c_ok - b_ok), 32'd1);
    chk("reset_recover_count", 32'(rec_dat.size() - b_rec), 32'd3);
    if (rec_dat.size() - b_rec == 3)
      chk("reset_recover_data", 32'({rec_dat[b_rec], rec_dat[b_rec+1], rec_dat[b_rec+2]}), 32'h112233);
    chk("single_pulse", 32'(c_multi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
